// File: rtl/max_pool_2d_ctrl.sv
// Streaming 2x2/stride-2 max-pool over raster-ordered pixel beats carrying NFMAPS
// signed channels. Even rows fill a line buffer; odd rows pair up with it to emit.

module max_pool_2d_lane #(
  parameter int NBITS = 32
) (
  input  logic signed [NBITS-1:0] a,
  input  logic signed [NBITS-1:0] b,
  input  logic signed [NBITS-1:0] c,
  input  logic signed [NBITS-1:0] d,
  output logic signed [NBITS-1:0] y
);
  logic signed [NBITS-1:0] ab, cd;

  always_comb begin
    ab = (a > b) ? a : b;
    cd = (c > d) ? c : d;
    y  = (ab > cd) ? ab : cd;
  end
endmodule

module max_pool_2d_ctrl #(
  parameter int NBITS  = 32,
  parameter int NFMAPS = 32,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NBITS*NFMAPS-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NBITS*NFMAPS-1:0] out_data,
  output logic                    frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef enum logic {FILL, POOL} state_t;
  typedef logic [NFMAPS-1:0][NBITS-1:0] pix_t;

  state_t        state, state_nx;
  logic [CW-1:0] col, col_even;
  logic [RW-1:0] row;
  pix_t          linebuf [IMG_W];
  pix_t          in_pix, held, lb_even, lb_odd, win_max;
  logic          accept, col_last, row_last;
  logic          lb_we, hold_en, emit, out_last;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));
  assign in_pix   = in_data;

  always_comb begin
    state_nx = state;
    lb_we    = 1'b0;
    hold_en  = 1'b0;
    emit     = 1'b0;
    if (accept) begin
      case (state)
        FILL: begin
          lb_we = 1'b1;
          if (col_last) state_nx = POOL;
        end
        POOL: begin
          if (col[0]) emit = 1'b1;
          else        hold_en = 1'b1;
          if (col_last) state_nx = FILL;
        end
        default: state_nx = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      col <= col_last ? '0 : col + CW'(1);
      if (col_last) row <= row_last ? '0 : row + RW'(1);
    end
  end

  // Line buffer is deliberately left out of reset; every entry is rewritten before use.
  always_ff @(posedge clk) begin
    if (lb_we) linebuf[col] <= in_pix;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)       held <= '0;
    else if (hold_en) held <= in_pix;
  end

  assign col_even = col & ~CW'(1);
  assign lb_even  = linebuf[col_even];
  assign lb_odd   = linebuf[col];

  for (genvar f = 0; f < NFMAPS; f++) begin : g_lane
    max_pool_2d_lane #(.NBITS(NBITS)) u_lane (
      .a (lb_even[f]),
      .b (lb_odd[f]),
      .c (held[f]),
      .d (in_pix[f]),
      .y (win_max[f])
    );
  end

  // A new result may land in the same cycle the old one drains, so emit wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_valid && out_ready && out_last;
      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= win_max;
        out_last  <= row_last && col_last;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_max_pool_2d_ctrl.sv
// Directed and randomized bench for max_pool_2d_ctrl; expectations come from a
// whole-image 2x2 max model and an in-order queue of pooled pixels.

module tb_max_pool_2d_ctrl;
  localparam int W = 4, H = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, frame_done;
  logic [15:0] in_data, out_data;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_frame_done;
  logic [15:0] b_in_data, b_out_data;

  int tests = 0, fails = 0;
  int k, n_done, n_stall;

  typedef struct packed {logic [15:0] data; logic last;} exp_t;
  exp_t        q[$];
  logic [7:0]  seen0[$];
  logic [15:0] img [H][W];
  logic [15:0] last_prod;
  logic [7:0]  pat [8];

  always #5 clk = ~clk;

  max_pool_2d_ctrl #(.NBITS(8), .NFMAPS(2), .IMG_W(W), .IMG_H(H)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .frame_done(frame_done)
  );

  max_pool_2d_ctrl #(.NBITS(8), .NFMAPS(2), .IMG_W(2), .IMG_H(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .frame_done(b_frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] smax(input logic [7:0] a, input logic [7:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  function automatic logic [15:0] mk(input logic [7:0] v);
    logic [7:0] n;
    n = 8'd0 - v;
    return {n, v};
  endfunction

  // Reference: store the frame as an image; at each bottom-right corner of a
  // 2x2 block, the pooled pixel is the per-channel max of that block.
  task automatic model_accept(input logic [15:0] d, output logic prod);
    int r, c;
    exp_t e;
    r = k / W;
    c = k % W;
    img[r][c] = d;
    prod = 1'b0;
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      for (int f = 0; f < 2; f++)
        e.data[f*8 +: 8] = smax(smax(img[r-1][c-1][f*8 +: 8], img[r-1][c][f*8 +: 8]),
                                smax(img[r][c-1][f*8 +: 8],   img[r][c][f*8 +: 8]));
      e.last = (r == H - 1) && (c == W - 1);
      q.push_back(e);
      last_prod = e.data;
      prod = 1'b1;
    end
    k = (k + 1) % (W * H);
  endtask

  task automatic step(input logic v, input logic [15:0] d, input logic rdy);
    logic acc, xfer, prod, done_exp;
    exp_t e;
    in_valid = v; in_data = d; out_ready = rdy;
    #1;
    chk("in_ready_rule", in_ready, !out_valid || out_ready);
    acc = in_valid && in_ready;
    xfer = out_valid && out_ready;
    prod = 1'b0;
    done_exp = 1'b0;
    if (v && rdy && !in_ready) n_stall++;
    if (xfer) begin
      if (q.size() == 0) chk("spurious_out", 1, 0);
      else begin
        e = q.pop_front();
        chk("out_data", out_data, e.data);
        done_exp = e.last;
        seen0.push_back(out_data[7:0]);
      end
    end
    if (acc) model_accept(d, prod);
    @(posedge clk); #1;
    if (prod) begin
      chk("lat_valid", out_valid, 1);
      chk("lat_data", out_data, last_prod);
    end else if (xfer) chk("valid_clear", out_valid, 0);
    chk("frame_done", frame_done, done_exp);
    if (frame_done) n_done++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;
    @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_b_out_valid", b_out_valid, 0);
    rst_n = 1'b1;
    k = 0; n_done = 0; q.delete(); seen0.delete();
  endtask

  task automatic send_pat(input logic rdy);
    for (int i = 0; i < 8; i++) step(1'b1, mk(pat[i]), rdy);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
  endtask

  task automatic chk_seen(input string tag, input logic [7:0] a, input logic [7:0] b);
    chk({tag, "_count"}, seen0.size(), 2);
    if (seen0.size() == 2) begin
      chk({tag, "_0"}, seen0[0], a);
      chk({tag, "_1"}, seen0[1], b);
    end
  endtask

  initial begin
    k = 0; n_done = 0; n_stall = 0; last_prod = '0;
    do_reset();

    // Basic ascending frame
    pat = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    send_pat(1'b1);
    chk_seen("basic", 8'd6, 8'd8);
    chk("basic_done_cnt", n_done, 1);

    // Signed compare
    seen0.delete(); n_done = 0;
    pat = '{8'hFF, 8'h80, 8'hFD, 8'hFC, 8'hFB, 8'hFA, 8'hF9, 8'hFE};
    send_pat(1'b1);
    chk_seen("signed", 8'hFF, 8'hFE);

    // Backpressure holding the first result
    seen0.delete();
    pat = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    for (int i = 0; i < 5; i++) step(1'b1, mk(pat[i]), 1'b1);
    step(1'b1, mk(8'd6), 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, mk(8'd7), 1'b0);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", out_data[7:0], 8'd6);
    end
    step(1'b1, mk(8'd7), 1'b1);
    step(1'b1, mk(8'd8), 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk_seen("bp", 8'd6, 8'd8);
    chk("bp_queue_empty", q.size(), 0);

    // Reset mid-frame
    for (int i = 0; i < 5; i++) step(1'b1, mk(pat[i]), 1'b1);
    do_reset();
    send_pat(1'b1);
    chk_seen("midrst", 8'd6, 8'd8);

    // Two-fmap, 2x2 image on the second instance
    b_out_ready = 1'b1;
    b_in_valid = 1'b1;
    b_in_data = 16'h0AFF; @(posedge clk); #1;
    b_in_data = 16'h0003; @(posedge clk); #1;
    b_in_data = 16'hEC02; @(posedge clk); #1;
    b_in_data = 16'h0500; @(posedge clk); #1;
    b_in_valid = 1'b0;
    chk("fm2_valid", b_out_valid, 1);
    chk("fm2_data", b_out_data, 16'h0A03);
    @(posedge clk); #1;
    chk("fm2_done", b_frame_done, 1);
    chk("fm2_cleared", b_out_valid, 0);

    // Back-to-back frames at full rate
    seen0.delete(); n_done = 0; n_stall = 0;
    for (int i = 0; i < 16; i++) step(1'b1, 16'($urandom), 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("b2b_stall", n_stall, 0);
    chk("b2b_outputs", seen0.size(), 4);
    chk("b2b_done_cnt", n_done, 2);

    // Random valid/ready traffic
    do_reset();
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 3) != 0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    chk("rand_queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
